logic_depth_path_accumulator: RTL

//  Streaming, parametrised successor of the combinational logic-depth predictor. Accepts one gate

---
 rtl/ldp_pkg.sv | 22 ++
 rtl/ldp_gate_cost.sv | 29 ++
 rtl/logic_depth_path_accumulator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ldp_pkg.sv
// rtl/ldp_pkg.sv - shared types and constants for the logic-depth path accumulator
//   gate_type_e : gate family encoding carried on gate_type
//   BASE_COST   : intrinsic depth cost per gate family, indexed by gate_type
//   ldp_state_e : path FSM states (ACCUM collects beats, EMIT holds a result)
package ldp_pkg;

  typedef enum logic [1:0] {
    GT_INV  = 2'd0,
    GT_NAND = 2'd1,
    GT_AND  = 2'd2,
    GT_XOR  = 2'd3
  } gate_type_e;

  // Packed so that BASE_COST[gate_type] picks the slice for that type (index 0 = LSB).
  localparam logic [3:0][1:0] BASE_COST = {2'd3, 2'd2, 2'd1, 2'd1};

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } ldp_state_e;

endpackage

// File: rtl/ldp_gate_cost.sv
// rtl/ldp_gate_cost.sv - combinational depth cost of one gate descriptor
//   fan_in    in  FI_W      gate fan-in; every 4 inputs add one level
//   fan_out   in  FO_W      gate fan-out; above FO_THRESH adds a load level
//   gate_type in  2         gate family, indexes BASE_COST
//   cost      out DEPTH_W+1 per-gate cost, wide enough that it never wraps
module ldp_gate_cost
  import ldp_pkg::*;
#(
  parameter int          FI_W      = 4,
  parameter int          FO_W      = 4,
  parameter int          DEPTH_W   = 8,
  parameter int unsigned FO_THRESH = 8
) (
  input  logic [FI_W-1:0]  fan_in,
  input  logic [FO_W-1:0]  fan_out,
  input  logic [1:0]       gate_type,
  output logic [DEPTH_W:0] cost
);

  localparam int CW = DEPTH_W + 1;

  logic load_penalty;

  always_comb begin
    load_penalty = (32'(fan_out) > FO_THRESH);
    cost = CW'(BASE_COST[gate_type]) + CW'(fan_in[FI_W-1:2]) + CW'(load_penalty);
  end

endmodule

// File: rtl/logic_depth_path_accumulator.sv
// rtl/logic_depth_path_accumulator.sv - streaming per-path saturating logic-depth accumulator
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      gate descriptor handshake
//   fan_in/fan_out/gate_type/in_last  descriptor fields; in_last closes the path
//   path_flush             drop the partial path (ignored while a result is pending)
//   out_valid/out_ready    path result handshake
//   out_depth/out_gates/out_sat  result: saturating depth, gate count, saturation flag
//   max_depth              largest emitted depth since reset (only with LDP_MAXTRACK_EN)
module logic_depth_path_accumulator
  import ldp_pkg::*;
#(
  parameter int          FI_W      = 4,
  parameter int          FO_W      = 4,
  parameter int          DEPTH_W   = 8,
  parameter int          CNT_W     = 8,
  parameter int unsigned FO_THRESH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FI_W-1:0]    fan_in,
  input  logic [FO_W-1:0]    fan_out,
  input  logic [1:0]         gate_type,
  input  logic               in_last,
  input  logic               path_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] out_depth,
  output logic [CNT_W-1:0]   out_gates,
`ifdef LDP_MAXTRACK_EN
  output logic [DEPTH_W-1:0] max_depth,
`endif
  output logic               out_sat
);

  localparam int                 SW        = DEPTH_W + 2;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  ldp_state_e         state_q, state_d;
  logic [DEPTH_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [DEPTH_W-1:0] out_depth_q, out_depth_d;
  logic [CNT_W-1:0]   out_gates_q, out_gates_d;
  logic               out_sat_q, out_sat_d;
`ifdef LDP_MAXTRACK_EN
  logic [DEPTH_W-1:0] max_depth_q, max_depth_d;
`endif

  logic [DEPTH_W:0]   cost;
  logic [SW-1:0]      sum;
  logic [DEPTH_W-1:0] acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               sat_next;
  logic               accept;

  ldp_gate_cost #(
    .FI_W      (FI_W),
    .FO_W      (FO_W),
    .DEPTH_W   (DEPTH_W),
    .FO_THRESH (FO_THRESH)
  ) u_cost (
    .fan_in    (fan_in),
    .fan_out   (fan_out),
    .gate_type (gate_type),
    .cost      (cost)
  );

  // rst_n gates in_ready so no beat looks acceptable while reset is held.
  assign in_ready = rst_n && (state_q == ACCUM) && !path_flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum      = SW'(acc_q) + SW'(cost);
    acc_next = (sum > SW'(DEPTH_MAX)) ? DEPTH_MAX : sum[DEPTH_W-1:0];
    cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    sat_next = sat_q || (sum > SW'(DEPTH_MAX)) || (cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_depth_d = out_depth_q;
    out_gates_d = out_gates_q;
    out_sat_d   = out_sat_q;
`ifdef LDP_MAXTRACK_EN
    max_depth_d = max_depth_q;
`endif
    case (state_q)
      ACCUM: begin
        if (path_flush) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (accept) begin
          if (in_last) begin
            out_depth_d = acc_next;
            out_gates_d = cnt_next;
            out_sat_d   = sat_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = EMIT;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            sat_d = sat_next;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
`ifdef LDP_MAXTRACK_EN
          if (out_depth_q > max_depth_q) max_depth_d = out_depth_q;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_depth_q <= '0;
      out_gates_q <= '0;
      out_sat_q   <= 1'b0;
`ifdef LDP_MAXTRACK_EN
      max_depth_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_depth_q <= out_depth_d;
      out_gates_q <= out_gates_d;
      out_sat_q   <= out_sat_d;
`ifdef LDP_MAXTRACK_EN
      max_depth_q <= max_depth_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_depth = out_depth_q;
  assign out_gates = out_gates_q;
  assign out_sat   = out_sat_q;
`ifdef LDP_MAXTRACK_EN
  assign max_depth = max_depth_q;
`endif

endmodule
